mem_initiator: RTL

- Initiator-side front end for the single-port word memory. It accepts one load/store request at a time from a core over a valid/ready request channel.
- It converts the byte address to a word index, drives the memory's write/addr/wdata pins, and waits out the memory's registered read latency.
- It returns read data or write completion over a valid/ready response channel. Illegal addresses are rejected locally and never reach the memory.

---
 rtl/mem_initiator.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_initiator.sv
// Single-outstanding load/store front end for the single-port word memory.
// Rejects misaligned or out-of-range addresses locally, waits out the read latency.
//
// state | meaning
// IDLE  | ready for a request, memory pins idle
// WRITE | one-cycle store strobe to the memory
// READ  | address held for READ_LATENCY+1 cycles, data captured on the last edge
// RESP  | response held until the consumer takes it
module mem_initiator #(
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

  localparam logic [2:0]  LAST_CNT = 3'(READ_LATENCY);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [29:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        addr_bad;

  assign addr_bad = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= 30'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[31:2];
          wdata_d = req_wdata;
          cnt_d   = 3'd0;
          if (addr_bad) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else if (req_write) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        state_d = RESP;
        err_d   = 1'b0;
        rdata_d = 32'd0;
      end
      READ: begin
        cnt_d = cnt_q + 3'd1;
        // cnt_q counts 0..READ_LATENCY, giving READ_LATENCY+1 cycles in READ
        if (cnt_q == LAST_CNT) begin
          state_d = RESP;
          rdata_d = mem_rdata;
          err_d   = 1'b0;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs gated by rst_n so the memory strobe drops as soon as reset asserts.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    busy       = 1'b0;
    if (rst_n) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE:  req_ready = 1'b1;
        WRITE: begin
          mem_write = 1'b1;
          mem_addr  = {2'b00, idx_q};
          mem_wdata = wdata_q;
        end
        READ:  mem_addr = {2'b00, idx_q};
        RESP:  resp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
